// File: rtl/smart_bus_drain_pkg.sv
// Shared definitions for the smart bus drain collector.
//   - drain_state_e : FSM state encoding (IDLE=0, SELECT=1, STALL=2, DONE=3)
//   - clog2         : ceiling log2, used for counter and pointer widths
package smart_bus_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_STALL  = 2'd2,
        ST_DONE   = 2'd3
    } drain_state_e;

    // Ceiling log2; a value of 1 yields 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/smart_bus_drain_if.sv
// Bus-side bundle of the smart bus drain collector.
//   row_select_out        : one-hot row select toward the MAC column
//   vertical_smart_bus_in : word arriving at the bottom of the column
//   out_data/out_valid/out_ready/out_last : output stream to the memory writer
// Modports:
//   master : the collector (drives selects and the output stream)
//   slave  : the environment (drives the bus word and out_ready)
interface smart_bus_drain_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_ROWS  = 4
);
    logic [NUM_ROWS-1:0]  row_select_out;
    logic [WORD_SIZE-1:0] vertical_smart_bus_in;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output row_select_out,
        output out_data,
        output out_valid,
        output out_last,
        input  vertical_smart_bus_in,
        input  out_ready
    );

    modport slave (
        input  row_select_out,
        input  out_data,
        input  out_valid,
        input  out_last,
        output vertical_smart_bus_in,
        output out_ready
    );
endinterface

// File: rtl/smart_drain_fifo.sv
// Synchronous show-ahead FIFO for captured column words.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle (ignored while full)
//   push_data  : entry to write
//   pop        : consume the head entry (ignored while empty)
//   head_data  : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module smart_drain_fifo
    import smart_bus_drain_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

    // Qualified handshakes: a full push or an empty pop has no effect.
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage array; cleared on reset so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count; push with pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/smart_bus_drain.sv
// Column-bottom collector for the systolic MAC array.
// Walks the rows of one column top to bottom, enabling each row's
// select_bottom_out_smart in turn, captures the word arriving on the
// vertical smart bus and buffers it for the output memory writer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start_in  : one-cycle drain request (honoured only when idle)
//   busy_out  : drain in progress (SELECT, STALL, DONE)
//   done_out  : one-cycle pulse after the last row has been captured
//   bus       : smart_bus_drain_if.master (row selects, bus word, output stream)
// Build option: define SMART_BUS_DRAIN_LAST_EN to carry a last-row flag
// through the FIFO onto out_last; otherwise out_last is tied low.
module smart_bus_drain
    import smart_bus_drain_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_ROWS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    smart_bus_drain_if.master bus
);
    localparam int ROW_W = clog2(NUM_ROWS);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
`ifdef SMART_BUS_DRAIN_LAST_EN
    localparam int ENTRY_W = WORD_SIZE + 1;
`else
    localparam int ENTRY_W = WORD_SIZE;
`endif
    localparam logic [NUM_ROWS-1:0] ROW_ONE = {{(NUM_ROWS-1){1'b0}}, 1'b1};

    drain_state_e        state_r;
    drain_state_e        next_state_s;
    logic [ROW_W-1:0]    row_idx_r;
    logic [ROW_W-1:0]    next_row_s;
    logic [NUM_ROWS-1:0] row_select_r;
    logic [NUM_ROWS-1:0] next_select_s;
    logic                busy_r;
    logic                done_r;

    logic                push_s;
    logic                pop_s;
    logic                last_row_s;
    logic                will_fill_s;
    logic [CNT_W:0]      count_after_s;
    logic [ENTRY_W-1:0]  push_entry_s;
    logic [ENTRY_W-1:0]  head_entry_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_s;

    assign last_row_s = (row_idx_r == ROW_W'(NUM_ROWS - 1));
    assign pop_s      = bus.out_ready & ~fifo_empty_s;

    // Occupancy after this edge assuming a capture: decides whether the
    // next row may be selected or the FSM must wait in STALL.
    assign count_after_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, 1'b1}
                         - {{CNT_W{1'b0}}, pop_s};
    assign will_fill_s   = (count_after_s == (CNT_W + 1)'(FIFO_DEPTH));

`ifdef SMART_BUS_DRAIN_LAST_EN
    assign push_entry_s  = {last_row_s, bus.vertical_smart_bus_in};
    assign bus.out_last  = head_entry_s[WORD_SIZE];
`else
    assign push_entry_s  = bus.vertical_smart_bus_in;
    assign bus.out_last  = 1'b0;
`endif
    assign bus.out_data       = head_entry_s[WORD_SIZE-1:0];
    assign bus.out_valid      = ~fifo_empty_s;
    assign bus.row_select_out = row_select_r;
    assign busy_out           = busy_r;
    assign done_out           = done_r;

    // Next-state, row counter and capture strobe.
    always_comb begin
        next_state_s = state_r;
        next_row_s   = row_idx_r;
        push_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    next_state_s = ST_SELECT;
                    next_row_s   = {ROW_W{1'b0}};
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // The selected row's word is on the bus this cycle.
                push_s = 1'b1;
                if (last_row_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_row_s = row_idx_r + ROW_W'(1);
                    if (will_fill_s) begin
                        next_state_s = ST_STALL;
                    end else begin
                        next_state_s = ST_SELECT;
                    end
                end
            end
            ST_STALL: begin
                // Registered full flag: resume one cycle after space appears.
                if (!fifo_full_s) begin
                    next_state_s = ST_SELECT;
                end else begin
                    next_state_s = ST_STALL;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot decode of the row that will be selected next cycle.
    always_comb begin
        next_select_s = {NUM_ROWS{1'b0}};
        if (next_state_s == ST_SELECT) begin
            next_select_s = ROW_ONE << next_row_s;
        end else begin
            next_select_s = {NUM_ROWS{1'b0}};
        end
    end

    // FSM state, row counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            row_idx_r    <= {ROW_W{1'b0}};
            row_select_r <= {NUM_ROWS{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            row_idx_r    <= next_row_s;
            row_select_r <= next_select_s;
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_DONE);
        end
    end

    smart_drain_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_smart_bus_drain.sv
// Directed testbench for smart_bus_drain (NUM_ROWS=4, FIFO_DEPTH=2).
module tb_smart_bus_drain;
    import smart_bus_drain_pkg::*;

`ifdef SMART_BUS_DRAIN_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_in = 1'b0;
    logic busy_out;
    logic done_out;
    int   total = 0;
    int   bad = 0;

    logic [15:0] row_word [4];
    logic [15:0] bus_val;

    smart_bus_drain_if #(.WORD_SIZE(16), .NUM_ROWS(4)) sbi ();

    smart_bus_drain #(
        .WORD_SIZE  (16),
        .NUM_ROWS   (4),
        .FIFO_DEPTH (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start_in (start_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .bus      (sbi.master)
    );

    always #5 clk = ~clk;

    // Column model: the selected row drives its word, otherwise a filler.
    always_comb begin
        bus_val = 16'hDEAD;
        for (int r = 0; r < 4; r++) begin
            if (sbi.row_select_out[r]) bus_val = row_word[r];
        end
    end
    assign sbi.vertical_smart_bus_in = bus_val;

    // Expected tables for the basic drain, cycles 1..6.
    logic [3:0]  exp_sel   [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    logic        exp_valid [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_data  [6] = '{16'h0000, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_last(input int idx);
        return (idx == 3) && LAST_EN;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_sel"},   32'(sbi.row_select_out), 32'h0);
        chk({pfx, "_valid"}, 32'(sbi.out_valid), 32'h0);
        chk({pfx, "_data"},  32'(sbi.out_data), 32'h0);
        chk({pfx, "_last"},  32'(sbi.out_last), 32'h0);
        chk({pfx, "_busy"},  32'(busy_out), 32'h0);
        chk({pfx, "_done"},  32'(done_out), 32'h0);
        chk({pfx, "_count"}, 32'(u_dut.fifo_count_s), 32'h0);
    endtask

    // Runs a fixed number of cycles starting at cycle 1 relative to the call,
    // checking row order, word order/flags and the done pulse count.
    task automatic collect(input string pfx, input int cycles, input int first_row,
                           input int first_word, input int restart_cycle);
        int nrow;
        int nword;
        int ndone;
        nrow  = first_row;
        nword = first_word;
        ndone = 0;
        for (int k = 1; k <= cycles; k++) begin
            start_in = (k == restart_cycle);
            if (sbi.row_select_out != 4'h0) begin
                chk($sformatf("%s_sel_row%0d", pfx, nrow), 32'(sbi.row_select_out), 32'd1 << nrow);
                nrow++;
            end
            if (sbi.out_valid && sbi.out_ready) begin
                chk($sformatf("%s_word%0d", pfx, nword), 32'(sbi.out_data), 32'(row_word[nword & 3]));
                chk($sformatf("%s_last%0d", pfx, nword), 32'(sbi.out_last), 32'(exp_last(nword)));
                nword++;
            end
            if (done_out) ndone++;
            tick();
        end
        start_in = 1'b0;
        chk({pfx, "_rows"},  32'(nrow), 32'd4);
        chk({pfx, "_words"}, 32'(nword), 32'd4);
        chk({pfx, "_dones"}, 32'(ndone), 32'd1);
        chk({pfx, "_idle"},  32'(busy_out), 32'h0);
    endtask

    initial begin
        sbi.out_ready = 1'b0;
        row_word = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic drain with the consumer always ready
        sbi.out_ready = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("basic_sel_c%0d", c + 1),   32'(sbi.row_select_out), 32'(exp_sel[c]));
            chk($sformatf("basic_valid_c%0d", c + 1), 32'(sbi.out_valid), 32'(exp_valid[c]));
            chk($sformatf("basic_busy_c%0d", c + 1),  32'(busy_out), 32'(exp_busy[c]));
            chk($sformatf("basic_done_c%0d", c + 1),  32'(done_out), 32'(exp_done[c]));
            if (exp_valid[c]) begin
                chk($sformatf("basic_data_c%0d", c + 1), 32'(sbi.out_data), 32'(exp_data[c]));
                chk($sformatf("basic_last_c%0d", c + 1), 32'(sbi.out_last), 32'(exp_last(c - 1)));
            end
            if (c >= 1 && c <= 4) begin
                chk($sformatf("basic_pushpop_count_c%0d", c + 1), 32'(u_dut.fifo_count_s), 32'd1);
            end
            tick();
        end

        // Backpressure: two captures fill the FIFO, then the FSM stalls
        row_word = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
        sbi.out_ready = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("bp_sel_c1", 32'(sbi.row_select_out), 32'h1);
        tick();
        chk("bp_sel_c2", 32'(sbi.row_select_out), 32'h2);
        tick();
        for (int c = 3; c <= 5; c++) begin
            chk($sformatf("bp_stall_sel_c%0d", c),   32'(sbi.row_select_out), 32'h0);
            chk($sformatf("bp_stall_busy_c%0d", c),  32'(busy_out), 32'h1);
            chk($sformatf("bp_stall_count_c%0d", c), 32'(u_dut.fifo_count_s), 32'd2);
            chk($sformatf("bp_hold_data_c%0d", c),   32'(sbi.out_data), 32'h0A01);
            chk($sformatf("bp_hold_valid_c%0d", c),  32'(sbi.out_valid), 32'h1);
            tick();
        end
        sbi.out_ready = 1'b1;
        collect("bp", 20, 2, 0, -1);

        // Ignored restart: start pulsed during cycle 2 of a drain
        row_word = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        collect("restart", 12, 0, 0, 2);

        // Reset mid-drain: asserted during cycle 3
        row_word = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
        sbi.out_ready = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        chk("midrst_pre_valid", 32'(sbi.out_valid), 32'h1);
        chk("midrst_pre_busy",  32'(busy_out), 32'h1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick();
        row_word = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        sbi.out_ready = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        collect("fresh", 12, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smart_bus_drain.md
# smart_bus_drain

Column-bottom collector for the systolic MAC array. It sequences the per-row `select_bottom_out_smart` controls so that each row's MAC drives its `bottom_out` word onto the shared vertical smart bus in turn. It captures each word at the bottom of the column, buffers the words in a small FIFO, and presents them on a valid/ready stream to the output memory writer. It is the receiving end of the vertical smart bus, which the smart MAC cells drive.

## Interface
- `WORD_SIZE`, 16, width of a bus word.
- `NUM_ROWS`, 4, number of smart MAC rows on the column; must be ≥2.
- `FIFO_DEPTH`, 4, output buffer entries; must be a power of two and ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_in` in 1: one-cycle request to drain all rows of the column.
- `row_select_out` out NUM_ROWS: one-hot; bit r drives `select_bottom_out_smart` of row r.
- `vertical_smart_bus_in` in WORD_SIZE: bus value arriving at the bottom of the column.
- `out_data` out WORD_SIZE: FIFO head word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_last` out 1: marks the word from row NUM_ROWS-1 (see Configuration).
- `busy_out` out 1: a drain is in progress.
- `done_out` out 1: one-cycle pulse when all rows have been captured.

## Operation
- The FSM has four states: IDLE, SELECT, STALL, DONE.
- Row counter `row_idx` has width clog2(NUM_ROWS) and counts from 0 upward, so row 0 (top) is drained first.
- IDLE:
  - `start_in` high moves the FSM to SELECT with `row_idx`=0.
  - `start_in` is ignored in every other state.
- SELECT:
  - `row_select_out` = 1<<`row_idx`.
  - On the clock edge ending the cycle, the bus word is pushed into the FIFO together with a last flag (`row_idx`==NUM_ROWS-1).
  - After the last row, go to DONE. Otherwise `row_idx`++.
  - If the FIFO will be full for the next push, go to STALL instead of selecting the next row.
  - "Full" is judged from the registered count including a pop in the same cycle: count − pop + push == FIFO_DEPTH.
- STALL:
  - `row_select_out`=0.
  - Return to SELECT on the cycle after the count drops below FIFO_DEPTH.
  - `row_idx` is held.
- DONE:
  - `done_out`=1 for exactly one cycle, then go to IDLE.
  - The FIFO keeps draining independently of the FSM.
- FIFO behaviour:
  - Show-ahead: `out_data` and `out_valid` come straight from the registered head.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop while empty does nothing.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push is never issued while the FIFO is full; the stall logic guarantees this.
- `busy_out` is high in SELECT, STALL and DONE.
- Words are unsigned pass-through. No arithmetic is applied.

## Timing
- Reset values:
  - `row_select_out`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
  - `busy_out`=0, `done_out`=0, FSM state=IDLE, FIFO count=0.
- Reset mid-drain aborts immediately. Partially collected FIFO contents are discarded.
- `start_in` sampled high at edge 0:
  - Row r is selected during cycle r+1 when there are no stalls.
  - First `out_valid` appears in cycle 2.
  - `done_out` is high in cycle NUM_ROWS+1.
- The bus is sampled in the same cycle its select is high. The MAC `bottom_out` is registered, so the mux chain is the only combinational path.
- A stall inserts a whole number of cycles with `row_select_out`=0. No row is skipped or repeated.
- `out_valid`, `out_data` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.

## Configuration
- Macro: `SMART_BUS_DRAIN_LAST_EN`.
- Defined: the FIFO stores WORD_SIZE+1 bits per entry, and `out_last` is high with the row NUM_ROWS-1 word.
- Undefined: the FIFO stores WORD_SIZE bits and `out_last` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `smart_bus_drain_pkg` holds:
  - the FSM state encodings (2 bits: IDLE=0, SELECT=1, STALL=2, DONE=3);
  - the clog2 helper function.
- One sub-module, `smart_drain_fifo`, implements the synchronous show-ahead FIFO:
  - parameters: width and depth;
  - ports: push, pop, full, empty, count.
- The top level holds the FSM, the row counter and the one-hot decode.

## Test plan
- Basic drain: NUM_ROWS=4, rows drive 0x0011/0x0022/0x0033/0x0044, `out_ready`=1 → `row_select_out` shows 0001, 0010, 0100, 1000 in cycles 1–4; words stream out in that order; `out_last` is high only on 0x0044; `done_out` pulses in cycle 5.
- Backpressure: FIFO_DEPTH=2 with `out_ready`=0 → after 2 captures, `row_select_out`=0 and the FSM sits in STALL. Raise `out_ready` → rows 2 and 3 are then captured and all 4 words arrive in order, with no loss or duplicate.
- Simultaneous push/pop at count=1 → count stays 1 and the order is preserved.
- Ignored restart: `start_in` pulsed in cycle 2 → no restart, exactly 4 words, one `done_out` pulse.
- Reset mid-drain: `rst` asserted in cycle 3 → all outputs return to their reset values at once; a subsequent start drains 4 fresh words.
- Macro off: run the basic-drain scenario → `out_last` stays 0 throughout and the data is unchanged.
